// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with pixel-clock divider; define VGA_TIMING_GEN_TEST_PATTERN_EN for built-in colour bars
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CLK_DIV  = 2,
    parameter int   CW       = 11
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic [7:0]    red,
    input  logic [7:0]    green,
    input  logic [7:0]    blue,
    output logic          VGA_CLK,
    output logic          VGA_HS,
    output logic          VGA_VS,
    output logic          VGA_BLANK_N,
    output logic          VGA_SYNC_N,
    output logic [7:0]    VGA_R,
    output logic [7:0]    VGA_G,
    output logic [7:0]    VGA_B,
    output logic [CW-1:0] next_x,
    output logic [CW-1:0] next_y,
    output logic          next_valid,
    output logic          line_start,
    output logic          frame_start
);
    localparam int            H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int            V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int            DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [DW-1:0] r_div;
    logic [DW-1:0] w_div_nxt;
    logic [CW-1:0] r_h;
    logic [CW-1:0] r_v;
    logic          w_tick;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_hs;
    logic          w_vs;
    logic [7:0]    w_r;
    logic [7:0]    w_g;
    logic [7:0]    w_b;

    // Pixel tick, counter wrap points and sync windows decoded from current counters
    always_comb begin
        w_tick    = r_div == DIV_LAST;
        w_div_nxt = w_tick ? '0 : r_div + 1'b1;
        w_h_wrap  = r_h == H_LAST;
        w_v_wrap  = r_v == V_LAST;
        w_hs      = (r_h >= HS_BEG && r_h < HS_END) ? HS_POL : ~HS_POL;
        w_vs      = (r_v >= VS_BEG && r_v < VS_END) ? VS_POL : ~VS_POL;
    end

    assign next_x      = r_h;
    assign next_y      = r_v;
    assign next_valid  = (r_h < H_ACT) && (r_v < V_ACT);
    assign line_start  = w_tick && (r_h == '0);
    assign frame_start = line_start && (r_v == '0);
    assign VGA_SYNC_N  = 1'b1;

`ifdef VGA_TIMING_GEN_TEST_PATTERN_EN
    localparam logic [CW-1:0] BAR_W = CW'(H_ACTIVE / 8);
    logic [CW-1:0] w_bar;
    logic          w_unused;
    assign w_bar    = r_h / BAR_W;
    assign w_r      = {8{~w_bar[1]}};
    assign w_g      = {8{~w_bar[2]}};
    assign w_b      = {8{~w_bar[0]}};
    assign w_unused = ^{red, green, blue, w_bar};
`else
    assign w_r = red;
    assign w_g = green;
    assign w_b = blue;
`endif

    // Divider; VGA_CLK is low for the first half of each pixel period and falls on the tick
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_div   <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            r_div   <= w_div_nxt;
            VGA_CLK <= w_div_nxt >= DIV_HALF;
        end
    end

    // Raster position advances once per pixel tick
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (w_tick) begin
            r_h <= w_h_wrap ? '0 : r_h + 1'b1;
            if (w_h_wrap) r_v <= w_v_wrap ? '0 : r_v + 1'b1;
        end
    end

    // Video outputs captured together on the tick, one pixel behind the counters
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else if (w_tick) begin
            VGA_HS      <= w_hs;
            VGA_VS      <= w_vs;
            VGA_BLANK_N <= next_valid;
            VGA_R       <= next_valid ? w_r : 8'h00;
            VGA_G       <= next_valid ? w_g : 8'h00;
            VGA_B       <= next_valid ? w_b : 8'h00;
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench over default, SVGA-like and tiny raster configurations
module tb_vga_timing_gen;
    typedef struct {
        int st, len, fs, bc, bf, hc, hf, vc, ac, lk, ms;
    } line_t;

    localparam int HA[3]   = '{640, 800, 8};
    localparam int HF[3]   = '{16, 40, 2};
    localparam int HSY[3]  = '{96, 128, 3};
    localparam int HB[3]   = '{48, 88, 3};
    localparam int VA[3]   = '{480, 600, 4};
    localparam int VF[3]   = '{10, 1, 1};
    localparam int VSY[3]  = '{2, 4, 2};
    localparam int VB[3]   = '{33, 23, 1};
    localparam int CD[3]   = '{2, 4, 4};
    localparam bit HP[3]   = '{1'b0, 1'b1, 1'b1};
    localparam bit VP[3]   = '{1'b0, 1'b1, 1'b1};
    localparam int S_BC[8] = '{8, 8, 8, 8, 0, 0, 0, 0};
    localparam int S_VC[8] = '{0, 0, 0, 0, 0, 16, 16, 0};

    logic CLOCK_50 = 1'b0;
    logic reset_n  = 1'b1;
    int   n_pass   = 0;
    int   n_tot    = 0;
    event ev_rst;

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input int g, input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL u%0d.%s actual=%0d required=%0d", g, nm, act, exp);
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int HT = HA[g] + HF[g] + HSY[g] + HB[g];
        logic        vclk, hs, vs, bn, sn, nv, ls, fs;
        logic [7:0]  r, gr, b, red, green, blue;
        logic [10:0] nx, ny;
        line_t       q[$];

        assign red   = nv ? 8'hAA : 8'h55;
        assign green = ny[7:0];
        assign blue  = nx[7:0];

        vga_timing_gen #(
            .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HSY[g]), .H_BP(HB[g]),
            .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VSY[g]), .V_BP(VB[g]),
            .HS_POL(HP[g]), .VS_POL(VP[g]), .CLK_DIV(CD[g]), .CW(11)
        ) u_dut (
            .CLOCK_50(CLOCK_50), .reset_n(reset_n),
            .red(red), .green(green), .blue(blue),
            .VGA_CLK(vclk), .VGA_HS(hs), .VGA_VS(vs),
            .VGA_BLANK_N(bn), .VGA_SYNC_N(sn),
            .VGA_R(r), .VGA_G(gr), .VGA_B(b),
            .next_x(nx), .next_y(ny), .next_valid(nv),
            .line_start(ls), .frame_start(fs)
        );

        // Monitor: gathers per-line statistics, compares against the queue head at each line_start
        initial begin
            line_t e;
            int cyc, k, l, st, lfs, bc, bf, hc, hf, vc, ac, lk, ms;
            bit in_line, pv;
            cyc = 0; k = 0; l = 0; st = 0; lfs = 0; in_line = 0; pv = 0;
            bc = 0; bf = -1; hc = 0; hf = -1; vc = 0; ac = 0; lk = 0; ms = 0;
            forever begin
                @(negedge CLOCK_50);
                if (!reset_n) begin
                    cyc = 0; in_line = 0; pv = 0;
                end else begin
                    cyc++;
                    if (ls) begin
                        if (in_line && q.size() > 0) begin
                            e = q.pop_front();
                            chk(g, "start_cyc", st, e.st);
                            chk(g, "line_len", cyc - st, e.len);
                            chk(g, "frame_start", lfs, e.fs);
                            chk(g, "blank_hi", bc, e.bc);
                            chk(g, "blank_first", bf, e.bf);
                            chk(g, "hs_cnt", hc, e.hc);
                            chk(g, "hs_first", hf, e.hf);
                            chk(g, "vs_cnt", vc, e.vc);
                            chk(g, "r_aa_cnt", ac, e.ac);
                            chk(g, "blank_leak", lk, e.lk);
                            chk(g, "data_mis", ms, e.ms);
                        end
                        l = fs ? 0 : l + 1;
                        in_line = 1; st = cyc; lfs = int'(fs); k = -1;
                        bc = 0; bf = -1; hc = 0; hf = -1; vc = 0; ac = 0; lk = 0; ms = 0;
                    end
                    if (pv && !vclk && in_line) begin
                        k++;
                        if (bn) begin
                            bc++;
                            if (bf < 0) bf = k;
                            if (int'(b) != k % 256 || int'(gr) != l % 256) ms++;
                        end else if ({r, gr, b} != 24'h0) lk++;
                        if (hs == HP[g]) begin
                            hc++;
                            if (hf < 0) hf = k;
                        end
                        if (vs == VP[g]) vc++;
                        if (r == 8'hAA) ac++;
                        if (k < HT - 1 && (int'(nx) != k + 1 || int'(ny) != l ||
                            nv != ((k + 1 < HA[g]) && (l < VA[g])))) ms++;
                        if (!sn) ms++;
                    end
                    pv = vclk;
                end
            end
        end

        // Reset-value checks, triggered while reset_n is held low
        initial begin
            forever begin
                @(ev_rst);
                chk(g, "rst_vclk", int'(vclk), 0);
                chk(g, "rst_hs", int'(hs), int'(!HP[g]));
                chk(g, "rst_vs", int'(vs), int'(!VP[g]));
                chk(g, "rst_blank", int'(bn), 0);
                chk(g, "rst_rgb", int'({r, gr, b}), 0);
                chk(g, "rst_ls_fs", int'({ls, fs}), 0);
                chk(g, "rst_xy", int'({nx, ny}), 0);
                chk(g, "rst_sync_n", int'(sn), 1);
            end
        end
    end

    task automatic push(input int g, input int st, input int len, input int fs,
                        input int bc, input int hc, input int hf, input int vc);
        line_t e;
        e.st = st; e.len = len; e.fs = fs; e.bc = bc; e.bf = (bc > 0) ? 0 : -1;
        e.hc = hc; e.hf = hf; e.vc = vc; e.ac = bc; e.lk = 0; e.ms = 0;
        if (g == 0) gi[0].q.push_back(e);
        else if (g == 1) gi[1].q.push_back(e);
        else gi[2].q.push_back(e);
    endtask

    initial begin
        int left;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #5 -> ev_rst;
        #1;
        for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < 2; j++) push(0, 2 + 1600 * j, 1600, int'(j == 0), 640, 96, 656, 0);
            for (int j = 0; j < 2; j++) push(1, 4 + 4224 * j, 4224, int'(j == 0), 800, 128, 840, 0);
            for (int j = 0; j < (p == 0 ? 16 : 8); j++)
                push(2, 4 + 64 * j, 64, int'(j % 8 == 0), S_BC[j % 8], 3, 10, S_VC[j % 8]);
            @(posedge CLOCK_50);
            #5 reset_n = 1'b1;
            left = 1;
            for (int i = 0; i < 12000 && left != 0; i++) begin
                @(negedge CLOCK_50);
                left = gi[0].q.size() + gi[1].q.size() + gi[2].q.size();
            end
            chk(3, "lines_pending", left, 0);
            if (p == 0) begin
                for (int i = 0; i < 4000 && gi[0].nx != 11'd300; i++) @(negedge CLOCK_50);
                chk(0, "reached_x300", int'(gi[0].nx), 300);
                #3 reset_n = 1'b0;
                #1 -> ev_rst;
                #1;
                repeat (3) @(posedge CLOCK_50);
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
